// File: rtl/maxpool_ctrl_pkg.sv
// Shared types and constants for the max-pool frame sequencer.
// Holds the FSM state encoding, error codes and the pooled-size helper.
package maxpool_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_OVF     = 2'b10;
  localparam logic [1:0] ERR_ABORT   = 2'b11;

  function automatic int pool_dim(
    input int n,
    input int k,
    input int s
  );
    return (n - k) / s + 1;
  endfunction

endpackage

// File: rtl/mp_addr_cnt.sv
// Loadable up-counter with enable, clear and terminal-count flag.
// Clear wins over load, load wins over enable.
module mp_addr_cnt #(
  parameter int            AW = 16,
  parameter logic [AW-1:0] TC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_load,
  input  logic [AW-1:0] i_load_val,
  input  logic          i_en,
  output logic [AW-1:0] o_cnt,
  output logic          o_tc
);

  logic [AW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == TC);

endmodule

// File: rtl/maxpool_seq_ctrl.sv
// Frame sequencer: clears the pool array, streams one feature map in,
// captures pooled results and reports completion with error status.
module maxpool_seq_ctrl
  import maxpool_ctrl_pkg::*;
#(
  parameter int IMG_W     = 32,
  parameter int IMG_H     = 32,
  parameter int POOL_K    = 3,
  parameter int POOL_S    = 2,
  parameter int AW        = 16,
  parameter int DRAIN_MAX = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic          i_hold,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic [1:0]    o_err_code,
  output logic          o_in_rd_en,
  output logic [AW-1:0] o_in_rd_addr,
  output logic          o_pool_clr,
  output logic          o_pool_data_valid,
  input  logic          i_pool_valid,
  output logic          o_out_wr_en,
  output logic [AW-1:0] o_out_wr_addr
);

  localparam int OUT_W = pool_dim(IMG_W, POOL_K, POOL_S);
  localparam int OUT_H = pool_dim(IMG_H, POOL_K, POOL_S);
  localparam int N_IN  = IMG_W * IMG_H;
  localparam int N_OUT = OUT_W * OUT_H;
  localparam int TW    = $clog2(DRAIN_MAX + 1);

  localparam logic [AW-1:0] RD_LAST = AW'(N_IN - 1);
  localparam logic [AW-1:0] WR_FULL = AW'(N_OUT);
  localparam logic [AW-1:0] WR_LAST = AW'(N_OUT - 1);
  localparam logic [TW-1:0] T_LAST  = TW'(DRAIN_MAX - 1);

  state_t        r_state;
  state_t        w_next;
  logic          r_err;
  logic [1:0]    r_code;
  logic          r_pdv;
  logic [TW-1:0] r_tmr;

  logic          w_go;
  logic          w_act;
  logic          w_run;
  logic          w_abort;
  logic          w_rd;
  logic          w_wr;
  logic          w_ovf;
  logic          w_wr_full;
  logic          w_tmo;
  logic [AW-1:0] w_rd_cnt;
  logic [AW-1:0] w_wr_cnt;
  logic          w_rd_tc;
  logic          w_wr_tc;

  assign w_go    = (r_state == S_IDLE) && i_start;
  assign w_run   = (r_state == S_FEED) || (r_state == S_DRAIN);
  assign w_act   = w_run || (r_state == S_CLR);
  assign w_abort = w_act && i_abort;
  assign w_rd    = (r_state == S_FEED) && !i_hold && !i_abort;
  assign w_wr    = w_run && i_pool_valid && !w_wr_tc;
  assign w_ovf   = w_run && i_pool_valid && w_wr_tc;

  // Counts this cycle's write, so a last write on the timeout cycle succeeds
  assign w_wr_full = w_wr_tc || (w_wr && (w_wr_cnt == WR_LAST));
  assign w_tmo     = (r_state == S_DRAIN) && (r_tmr == T_LAST) && !w_wr_full;

  mp_addr_cnt #(
    .AW (AW),
    .TC (RD_LAST)
  ) u_rd_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_go),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_en       (w_rd),
    .o_cnt      (w_rd_cnt),
    .o_tc       (w_rd_tc)
  );

  mp_addr_cnt #(
    .AW (AW),
    .TC (WR_FULL)
  ) u_wr_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_go),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_en       (w_wr),
    .o_cnt      (w_wr_cnt),
    .o_tc       (w_wr_tc)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (i_start) w_next = S_CLR;
      S_CLR:   w_next = i_abort ? S_DONE : S_FEED;
      S_FEED: begin
        if (i_abort)              w_next = S_DONE;
        else if (w_rd && w_rd_tc) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (i_abort || w_wr_full || (r_tmr == T_LAST))
          w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pdv   <= 1'b0;
      r_tmr   <= '0;
    end else begin
      r_state <= w_next;
      r_pdv   <= w_rd;
      r_tmr   <= (r_state == S_DRAIN) ? r_tmr + 1'b1 : '0;
    end
  end

  // First recorded error sticks; abort always takes over
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err  <= 1'b0;
      r_code <= ERR_NONE;
    end else if (w_go) begin
      r_err  <= 1'b0;
      r_code <= ERR_NONE;
    end else if (w_abort) begin
      r_err  <= 1'b1;
      r_code <= ERR_ABORT;
    end else if (r_code == ERR_NONE) begin
      if (w_tmo) begin
        r_err  <= 1'b1;
        r_code <= ERR_TIMEOUT;
      end else if (w_ovf) begin
        r_err  <= 1'b1;
        r_code <= ERR_OVF;
      end
    end
  end

  assign o_busy            = w_act;
  assign o_done            = (r_state == S_DONE);
  assign o_err             = r_err;
  assign o_err_code        = r_code;
  assign o_in_rd_en        = w_rd;
  assign o_in_rd_addr      = w_rd_cnt;
  assign o_pool_clr        = (r_state == S_CLR);
  assign o_pool_data_valid = r_pdv;
  assign o_out_wr_en       = w_wr;
  assign o_out_wr_addr     = w_wr_cnt;

endmodule
